// File: rtl/ps2_key_fifo_pkg.sv
// Shared constants for the PS/2 key FIFO: overflow-policy encodings, default
// sizes and the per-cycle action decode used by the FIFO controller.
package ps2_key_fifo_pkg;

  localparam int DROP_NEW       = 0;
  localparam int OVERWRITE_OLD  = 1;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_PUSH,
    ACT_POP,
    ACT_PUSH_POP,
    ACT_DROP,
    ACT_OVERWRITE
  } fifo_act_e;

  // A pop frees a slot in the same cycle, so push+pop never overflows.
  function automatic fifo_act_e decode_act(input logic push,
                                           input logic pop,
                                           input logic is_full,
                                           input logic overwrite);
    fifo_act_e act;
    act = ACT_IDLE;
    if (push && pop)       act = ACT_PUSH_POP;
    else if (push && !is_full) act = ACT_PUSH;
    else if (push)         act = overwrite ? ACT_OVERWRITE : ACT_DROP;
    else if (pop)          act = ACT_POP;
    return act;
  endfunction

endpackage

// File: rtl/ps2_key_fifo_rise_detect.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of in.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clock) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  // History clears to 0, so a strobe already high out of reset counts as an edge.
  assign pulse = in & ~in_q;

endmodule

// File: rtl/ps2_key_fifo.sv
// Key-code FIFO between the PS/2 receiver and the processor: one entry per
// strobe rising edge, show-ahead read, sticky overflow with selectable policy.
module ps2_key_fifo
  import ps2_key_fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int OVF_MODE = DROP_NEW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ps2_key_pressed,
  input  logic [DATA_W-1:0]          ps2_out,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic              vld_p0;
  logic              pop;
  fifo_act_e         act;
  logic              wr_en, adv_head, cnt_inc, cnt_dec, set_ovf;

  rise_detect u_rise_detect (
    .clock (clock),
    .reset (reset),
    .in    (ps2_key_pressed),
    .pulse (vld_p0)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = rd_en && !empty;

  always_comb begin
    act      = decode_act(vld_p0, pop, full, OVF_MODE == OVERWRITE_OLD);
    wr_en    = 1'b0;
    adv_head = 1'b0;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    set_ovf  = 1'b0;
    case (act)
      ACT_PUSH:      begin wr_en = 1'b1; cnt_inc = 1'b1; end
      ACT_POP:       begin adv_head = 1'b1; cnt_dec = 1'b1; end
      ACT_PUSH_POP:  begin wr_en = 1'b1; adv_head = 1'b1; end
      ACT_DROP:      set_ovf = 1'b1;
      ACT_OVERWRITE: begin wr_en = 1'b1; adv_head = 1'b1; set_ovf = 1'b1; end
      default:       ;
    endcase
  end

  // Stage p0 -> storage: key code captured on the edge-detect cycle.
  always_ff @(posedge clock) begin
    if (wr_en) mem[tail_q] <= ps2_out;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en)    tail_q <= tail_q + PTR_W'(1);
      if (adv_head) head_q <= head_q + PTR_W'(1);
      if (cnt_inc)      count_q <= count_q + CNT_W'(1);
      else if (cnt_dec) count_q <= count_q - CNT_W'(1);
      if (set_ovf)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign rd_data = mem[head_q];
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: drop-newest and overwrite-oldest instances share the
// same stimulus; a queue model is compared every cycle plus literal expectations.
module tb_ps2_key_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset, strobe, rd_en, clr_ovf;
  logic [DW-1:0] ps2_out;
  logic [DW-1:0] rd_data [2];
  logic          empty [2], full [2], ovf [2];
  logic [CW-1:0] count [2];

  ps2_key_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .OVF_MODE(0)) dut_drop (
    .clock(clock), .reset(reset), .ps2_key_pressed(strobe), .ps2_out(ps2_out),
    .rd_en(rd_en), .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
    .count(count[0]), .ovf(ovf[0]), .clr_ovf(clr_ovf));

  ps2_key_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .OVF_MODE(1)) dut_ovw (
    .clock(clock), .reset(reset), .ps2_key_pressed(strobe), .ps2_out(ps2_out),
    .rd_en(rd_en), .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
    .count(count[1]), .ovf(ovf[1]), .clr_ovf(clr_ovf));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a key queue per policy plus a sticky flag.
  int  mq0[$];
  int  mq1[$];
  bit  mov[2];
  bit  prev_strobe;
  bit  model_on = 1'b0;

  task automatic model_q(inout int q[$], inout bit ov, input bit overwrite,
                         input bit push, input bit pop_req, input bit clr, input int val);
    bit of;
    of = 1'b0;
    if (pop_req && q.size() > 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(val);
      else begin
        of = 1'b1;
        if (overwrite) begin
          void'(q.pop_front());
          q.push_back(val);
        end
      end
    end
    if (of)       ov = 1'b1;
    else if (clr) ov = 1'b0;
  endtask

  task automatic cmp(input int id, input int q[$], input bit ov);
    chk($sformatf("count%0d", id), 64'(count[id]), 64'(q.size()));
    chk($sformatf("empty%0d", id), 64'(empty[id]), 64'(q.size() == 0));
    chk($sformatf("full%0d", id),  64'(full[id]),  64'(q.size() == DEPTH));
    chk($sformatf("ovf%0d", id),   64'(ovf[id]),   64'(ov));
    if (q.size() > 0) chk($sformatf("rd_data%0d", id), 64'(rd_data[id]), 64'(q[0]));
  endtask

  always @(posedge clock) begin
    bit push;
    if (reset) begin
      mq0.delete();
      mq1.delete();
      mov[0] = 1'b0;
      mov[1] = 1'b0;
      prev_strobe = 1'b0;
      model_on = 1'b1;
    end else begin
      push = strobe && !prev_strobe;
      prev_strobe = strobe;
      model_q(mq0, mov[0], 1'b0, push, rd_en, clr_ovf, int'(ps2_out));
      model_q(mq1, mov[1], 1'b1, push, rd_en, clr_ovf, int'(ps2_out));
    end
    #1;
    if (model_on) begin
      cmp(0, mq0, mov[0]);
      cmp(1, mq1, mov[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_key(input int val);
    strobe = 1'b1; ps2_out = DW'(val);
    cyc(1);
    strobe = 1'b0;
    cyc(1);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic chk_both(input string name, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] exp);
    chk({name, "_drop"}, a0, exp);
    chk({name, "_ovw"},  a1, exp);
  endtask

  initial begin
    reset = 1'b1; strobe = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; ps2_out = '0;
    cyc(2);
    chk_both("rst_count", 64'(count[0]), 64'(count[1]), 0);
    chk_both("rst_empty", 64'(empty[0]), 64'(empty[1]), 1);
    chk_both("rst_full",  64'(full[0]),  64'(full[1]),  0);
    chk_both("rst_ovf",   64'(ovf[0]),   64'(ovf[1]),   0);
    reset = 1'b0;
    cyc(1);

    // Strobe held two cycles yields one entry.
    strobe = 1'b1; ps2_out = 5;
    cyc(2);
    strobe = 1'b0;
    cyc(1);
    chk_both("hold_count", 64'(count[0]), 64'(count[1]), 1);
    chk_both("hold_data",  64'(rd_data[0]), 64'(rd_data[1]), 5);
    pop1();
    chk_both("hold_empty", 64'(empty[0]), 64'(empty[1]), 1);

    // Order 5, 11, 3.
    push_key(5); push_key(11); push_key(3);
    chk_both("ord_data0", 64'(rd_data[0]), 64'(rd_data[1]), 5);  pop1();
    chk_both("ord_data1", 64'(rd_data[0]), 64'(rd_data[1]), 11); pop1();
    chk_both("ord_data2", 64'(rd_data[0]), 64'(rd_data[1]), 3);  pop1();
    chk_both("ord_empty", 64'(empty[0]), 64'(empty[1]), 1);
    chk_both("ord_count", 64'(count[0]), 64'(count[1]), 0);

    // Overflow with 1..9 under both policies.
    for (int v = 1; v <= 9; v++) push_key(v);
    chk_both("ovf_count", 64'(count[0]), 64'(count[1]), 8);
    chk_both("ovf_flag",  64'(ovf[0]),   64'(ovf[1]),   1);
    chk_both("ovf_full",  64'(full[0]),  64'(full[1]),  1);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk_both("ovf_clr", 64'(ovf[0]), 64'(ovf[1]), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drop_seq%0d", i), 64'(rd_data[0]), 64'(i + 1));
      chk($sformatf("ovw_seq%0d", i),  64'(rd_data[1]), 64'(i + 2));
      pop1();
    end
    chk_both("ovf_drained", 64'(empty[0]), 64'(empty[1]), 1);

    // Push 20 with a pop while full.
    for (int v = 1; v <= 8; v++) push_key(v);
    strobe = 1'b1; ps2_out = 20; rd_en = 1'b1;
    cyc(1);
    strobe = 1'b0; rd_en = 1'b0;
    cyc(1);
    chk_both("pp_count", 64'(count[0]), 64'(count[1]), 8);
    chk_both("pp_ovf",   64'(ovf[0]),   64'(ovf[1]),   0);
    for (int i = 0; i < 8; i++) begin
      chk_both($sformatf("pp_seq%0d", i), 64'(rd_data[0]), 64'(rd_data[1]),
               (i < 7) ? 64'(i + 2) : 64'd20);
      pop1();
    end

    // Overflow and clr_ovf in the same cycle: set wins.
    for (int v = 1; v <= 8; v++) push_key(v);
    strobe = 1'b1; ps2_out = 9; clr_ovf = 1'b1;
    cyc(1);
    strobe = 1'b0; clr_ovf = 1'b0;
    cyc(1);
    chk_both("setwin_ovf", 64'(ovf[0]), 64'(ovf[1]), 1);
    clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
    chk_both("setwin_clr", 64'(ovf[0]), 64'(ovf[1]), 0);

    // Reset after three pushes, then read while empty.
    reset = 1'b1; cyc(1); reset = 1'b0;
    push_key(4); push_key(6); push_key(8);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk_both("r3_count", 64'(count[0]), 64'(count[1]), 0);
    chk_both("r3_empty", 64'(empty[0]), 64'(empty[1]), 1);
    chk_both("r3_ovf",   64'(ovf[0]),   64'(ovf[1]),   0);
    rd_en = 1'b1; cyc(2); rd_en = 1'b0;
    chk_both("rd_empty_count", 64'(count[0]), 64'(count[1]), 0);

    // Strobe already high as reset releases.
    reset = 1'b1; strobe = 1'b1; ps2_out = 7;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk_both("rel_count", 64'(count[0]), 64'(count[1]), 1);
    chk_both("rel_data",  64'(rd_data[0]), 64'(rd_data[1]), 7);
    cyc(2);
    chk_both("rel_hold", 64'(count[0]), 64'(count[1]), 1);
    strobe = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one key code word.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; a power of two, at least 2.
REQ-003 SHALL have parameter OVF_MODE, default 0, full policy: 0 = drop newest, 1 = overwrite oldest.
REQ-004 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ps2_key_pressed  input  1  key strobe from the PS/2 interface; may stay high for several cycles.
REQ-007 SHALL have port ps2_out  input  DATA_W  key code, valid while ps2_key_pressed is high.
REQ-008 SHALL have port rd_en  input  1  processor pops the head entry.
REQ-009 SHALL have port rd_data  output  DATA_W  head entry (show-ahead).
REQ-010 SHALL have port empty  output  1  no entries held.
REQ-011 SHALL have port full  output  1  DEPTH entries held.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  number of entries held.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port clr_ovf  input  1  clears ovf.

Function
REQ-015 SHALL detect a push as a 0->1 transition of ps2_key_pressed between consecutive cycles; a strobe held high for N cycles SHALL yield exactly one push.
REQ-016 SHALL capture ps2_out in the same cycle as the detected edge.
REQ-017 SHALL write a pushed entry at that clock edge; empty SHALL deassert and count SHALL increment in the following cycle (1-cycle latency).
REQ-018 SHALL drive rd_data combinationally from the head entry; rd_data SHALL be don't-care while empty.
REQ-019 SHALL, on rd_en with empty low, advance the head pointer and decrement count at the clock edge.
REQ-020 SHALL ignore rd_en while empty: no pointer change, no error flag.
REQ-021 SHALL, on a simultaneous push and pop, perform both with count unchanged; when full, this SHALL NOT set ovf.
REQ-022 SHALL, on a push while full without a pop in OVF_MODE 0, discard the new code, leave the contents unchanged and set ovf.
REQ-023 SHALL, on a push while full without a pop in OVF_MODE 1, advance the head pointer, write the new code at the tail, keep count at DEPTH and set ovf.
REQ-024 SHALL wrap the head and tail pointers modulo DEPTH; full and empty SHALL derive from count, never from pointer equality alone.
REQ-025 SHALL clear ovf on clr_ovf; a clr_ovf in the same cycle as a new overflow SHALL leave ovf set (set wins).
REQ-026 SHALL assert full exactly when count equals DEPTH and empty exactly when count equals 0.

Reset
REQ-027 SHALL, on reset, set the head pointer, tail pointer and count to 0, empty to 1, full to 0 and ovf to 0, and clear the edge-detect history register to 0.
REQ-028 SHALL give reset priority over push, pop and clr_ovf in the same cycle.
REQ-029 SHALL NOT require the storage array to be cleared by reset.
REQ-030 SHALL treat a strobe already high when reset deasserts as a push on the first cycle after reset.

Structure
REQ-031 SHALL place the OVF_MODE encodings (DROP_NEW=0, OVERWRITE_OLD=1) and the default DATA_W and DEPTH in the shared constants include file.
REQ-032 SHALL implement the edge detector as sub-module rise_detect (clock, reset, in, pulse).
REQ-033 SHALL keep the storage as a single register array with one write port and one read port.

Verification
REQ-034 Bench SHALL hold the strobe high for 2 cycles with ps2_out=5 -> count=1, rd_data=5 one cycle later, and no second entry.
REQ-035 Bench SHALL push 5, 11 and 3, then pop three times -> rd_data 5, 11, 3 in order, then empty=1 and count=0.
REQ-036 Bench SHALL, with DEPTH=8 and OVF_MODE=0, push 1..9 -> count=8, ovf=1 and a pop sequence 1..8.
REQ-037 Bench SHALL, with DEPTH=8 and OVF_MODE=1, push 1..9 -> count=8, ovf=1 and a pop sequence 2..9.
REQ-038 Bench SHALL, when full, push 20 and pop in the same cycle -> count=8, ovf=0, with 20 last in the pop order.
REQ-039 Bench SHALL assert reset after 3 pushes -> next cycle count=0, empty=1, ovf=0, and rd_en while empty leaves count=0.
